// File: rtl/aspiradora_pkg.sv
// Shared types for the multimode vacuum-robot controller.
// state_t carries the bit-exact state codes exposed on state_0.
// act_t groups the actuator enables decoded from a state.
package aspiradora_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_EXPLORE = 3'd1,
        ST_CLEAN   = 3'd2,
        ST_EVADE   = 3'd3,
        ST_RETURN  = 3'd4,
        ST_CHARGE  = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    typedef struct packed {
        logic motor;
        logic brush;
        logic turn;
        logic dock;
        logic fault;
    } act_t;

    // Actuator enables implied by a state (Moore decode).
    function automatic act_t decode_act(input state_t st);
        act_t a;
        a = '0;
        case (st)
            ST_EXPLORE: a.motor = 1'b1;
            ST_CLEAN:   begin a.motor = 1'b1; a.brush = 1'b1; end
            ST_EVADE:   a.turn = 1'b1;
            ST_RETURN:  begin a.motor = 1'b1; a.dock = 1'b1; end
            ST_FAULT:   a.fault = 1'b1;
            default:    a = '0;
        endcase
        return a;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aspiradora_dwell_timer.sv
// Saturating up-counter measuring residency in the current state.
// Ports: clk, rst (sync, active-high), clr (sync zero), en (count enable),
//        count (current value, holds at all-ones instead of wrapping).
module aspiradora_dwell_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fsm_aspiradora_multimodo.sv
// Multimode vacuum-robot Moore controller: explore, timed clean dwell, timed
// evade with retry, battery-driven return-to-dock and charging.
// Optional feature macro: ASPIRADORA_STUCK_FAULT_EN (evade retry limit -> FAULT).
// Ports: clk; power_off (sync active-high reset to OFF); on, dirt, obstacle,
//        docked, batt_level (sensor inputs); state_0 (state code);
//        motor_en, brush_en, turn_en, dock_req, fault (actuator enables).
module fsm_aspiradora_multimodo
    import aspiradora_pkg::*;
#(
    parameter int unsigned BATT_W          = 8,
    parameter int unsigned BATT_LOW        = 20,
    parameter int unsigned BATT_FULL       = 250,
    parameter int unsigned CLEAN_MIN_CYC   = 8,
    parameter int unsigned EVADE_CYC       = 4,
    parameter int unsigned MAX_EVADE_RETRY = 3
) (
    input  logic              clk,
    input  logic              power_off,
    input  logic              on,
    input  logic              dirt,
    input  logic              obstacle,
    input  logic              docked,
    input  logic [BATT_W-1:0] batt_level,
    output logic [2:0]        state_0,
    output logic              motor_en,
    output logic              brush_en,
    output logic              turn_en,
    output logic              dock_req,
    output logic              fault
);

    localparam int unsigned       DW         = $clog2(max_u(CLEAN_MIN_CYC, EVADE_CYC) + 1);
    localparam logic [DW-1:0]     CLEAN_LAST = DW'(CLEAN_MIN_CYC - 1);
    localparam logic [DW-1:0]     EVADE_LAST = DW'(EVADE_CYC - 1);
    localparam logic [BATT_W-1:0] LOW_LVL    = BATT_W'(BATT_LOW);
    localparam logic [BATT_W-1:0] FULL_LVL   = BATT_W'(BATT_FULL);

    if (CLEAN_MIN_CYC == 0 || EVADE_CYC == 0 || MAX_EVADE_RETRY == 0) begin : g_bad_param
        $error("dwell and retry parameters must be >= 1");
    end

    state_t        state;
    state_t        next_state;
    act_t          act_d;
    act_t          act_q;
    logic [DW-1:0] dwell;
    logic          dwell_clr;
    logic          evade_restart;
    logic          low;

`ifdef ASPIRADORA_STUCK_FAULT_EN
    localparam int unsigned   RW        = max_u(1, $clog2(MAX_EVADE_RETRY + 1));
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_EVADE_RETRY);
    logic [RW-1:0] retry;
    logic          retry_clr;
    logic          retry_inc;
`endif

    always_comb low = (batt_level <= LOW_LVL);

    // Next-state logic; priority is low battery, then obstacle, then dirt.
    always_comb begin
        next_state    = state;
        evade_restart = 1'b0;
`ifdef ASPIRADORA_STUCK_FAULT_EN
        retry_clr     = 1'b0;
        retry_inc     = 1'b0;
`endif
        case (state)
            ST_OFF: begin
                if (on) next_state = low ? ST_RETURN : ST_EXPLORE;
            end
            ST_EXPLORE: begin
                if (low)           next_state = ST_RETURN;
                else if (obstacle) next_state = ST_EVADE;
                else if (dirt)     next_state = ST_CLEAN;
            end
            ST_CLEAN: begin
                if (low)                                next_state = ST_RETURN;
                else if (obstacle)                      next_state = ST_EVADE;
                else if (!dirt && (dwell >= CLEAN_LAST)) next_state = ST_EXPLORE;
            end
            ST_EVADE: begin
                // obstacle only matters on the last manoeuvre cycle
                if (low) begin
                    next_state = ST_RETURN;
                end else if (dwell >= EVADE_LAST) begin
                    if (!obstacle) begin
                        next_state = ST_EXPLORE;
`ifdef ASPIRADORA_STUCK_FAULT_EN
                        retry_clr  = 1'b1;
                    end else if (retry == RETRY_MAX) begin
                        next_state = ST_FAULT;
                    end else begin
                        evade_restart = 1'b1;
                        retry_inc     = 1'b1;
                    end
`else
                    end else begin
                        evade_restart = 1'b1;
                    end
`endif
                end
            end
            ST_RETURN: begin
                if (docked) next_state = ST_CHARGE;
            end
            ST_CHARGE: begin
                if (batt_level >= FULL_LVL) next_state = ST_EXPLORE;
                else if (!docked)           next_state = ST_RETURN;
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_OFF;
        endcase
    end

    // Outputs are registered from the decode of next_state so they align with state.
    always_comb begin
        act_d = decode_act(next_state);
`ifndef ASPIRADORA_STUCK_FAULT_EN
        act_d.fault = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (power_off) begin
            state <= ST_OFF;
            act_q <= '0;
        end else begin
            state <= next_state;
            act_q <= act_d;
        end
    end

`ifdef ASPIRADORA_STUCK_FAULT_EN
    always_ff @(posedge clk) begin
        if (power_off || retry_clr) begin
            retry <= '0;
        end else if (retry_inc) begin
            retry <= retry + RW'(1);
        end
    end
`endif

    // One timer serves both CLEAN and EVADE; any state change restarts it.
    assign dwell_clr = (next_state != state) || evade_restart;

    aspiradora_dwell_timer #(
        .WIDTH (DW)
    ) u_dwell (
        .clk   (clk),
        .rst   (power_off),
        .clr   (dwell_clr),
        .en    (1'b1),
        .count (dwell)
    );

    assign state_0  = state;
    assign motor_en = act_q.motor;
    assign brush_en = act_q.brush;
    assign turn_en  = act_q.turn;
    assign dock_req = act_q.dock;
    assign fault    = act_q.fault;

endmodule

// File: tb/tb_fsm_aspiradora_multimodo.sv
// Self-checking bench for fsm_aspiradora_multimodo: directed scenarios plus
// randomized traffic, checked against a behavioural model of the robot.
// Honours ASPIRADORA_STUCK_FAULT_EN the same way as the design.
module tb_fsm_aspiradora_multimodo;

    localparam int BATT_LOW  = 20;
    localparam int BATT_FULL = 250;
    localparam int CLEAN_MIN = 8;
    localparam int EVADE_N   = 4;
    localparam int MAX_RETRY = 3;
`ifdef ASPIRADORA_STUCK_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       power_off, on, dirt, obstacle, docked;
    logic [7:0] batt_level;
    logic [2:0] state_0;
    logic       motor_en, brush_en, turn_en, dock_req, fault;

    int n_checks = 0;
    int n_fail   = 0;

    // model: current mode, cycles spent in this visit, evade restarts so far
    int m_st, m_age, m_retry;

    always #5 clk = ~clk;

    fsm_aspiradora_multimodo #(
        .BATT_W(8), .BATT_LOW(BATT_LOW), .BATT_FULL(BATT_FULL),
        .CLEAN_MIN_CYC(CLEAN_MIN), .EVADE_CYC(EVADE_N), .MAX_EVADE_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .power_off(power_off), .on(on), .dirt(dirt), .obstacle(obstacle),
        .docked(docked), .batt_level(batt_level), .state_0(state_0),
        .motor_en(motor_en), .brush_en(brush_en), .turn_en(turn_en),
        .dock_req(dock_req), .fault(fault)
    );

    // Robot behaviour, one clock edge at a time.
    function automatic void model_step();
        int nst;
        bit restart;
        bit low;
        if (power_off) begin
            m_st = 0; m_age = 0; m_retry = 0;
            return;
        end
        low = (int'(batt_level) <= BATT_LOW);
        nst = m_st;
        restart = 1'b0;
        case (m_st)
            0: if (on) nst = low ? 4 : 1;
            1: if (low) nst = 4; else if (obstacle) nst = 3; else if (dirt) nst = 2;
            2: if (low) nst = 4; else if (obstacle) nst = 3;
               else if (!dirt && (m_age + 1 >= CLEAN_MIN)) nst = 1;
            3: if (low) nst = 4;
               else if (m_age + 1 >= EVADE_N) begin
                   if (!obstacle) begin nst = 1; m_retry = 0; end
                   else if (FAULT_EN && m_retry == MAX_RETRY) nst = 6;
                   else begin restart = 1'b1; m_retry++; end
               end
            4: if (docked) nst = 5;
            5: if (int'(batt_level) >= BATT_FULL) nst = 1; else if (!docked) nst = 4;
            6: nst = 6;
            default: nst = 0;
        endcase
        m_age = (nst != m_st || restart) ? 0 : m_age + 1;
        m_st  = nst;
    endfunction

    // Expected {state_0, motor, brush, turn, dock, fault} for the model mode.
    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        v[7:5] = 3'(m_st);
        v[4]   = (m_st == 1 || m_st == 2 || m_st == 4);
        v[3]   = (m_st == 2);
        v[2]   = (m_st == 3);
        v[1]   = (m_st == 4);
        v[0]   = (m_st == 6);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        power_off = 1'b1; on = 1'b0; dirt = 1'b0; obstacle = 1'b0; docked = 1'b0;
        batt_level = 8'd100;
        tick();
        power_off = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset got=%b exp=%b", {state_0, motor_en, brush_en, turn_en, dock_req, fault}, 8'h00);
        end
        tick();
        n_checks++;
        if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got=%b exp=%b", {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
        end
    endtask

    task automatic test_clean_dwell();
        int brush_cnt;
        brush_cnt = 0;
        do_reset();
        on = 1'b1; tick();
        on = 1'b0; dirt = 1'b1; tick();
        dirt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
                n_fail++;
                $display("FAIL clean_dwell[%0d] got=%b exp=%b", i, {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
            end
            if (brush_en) brush_cnt++;
            tick();
        end
        n_checks++;
        if (brush_cnt != CLEAN_MIN || state_0 !== 3'd1) begin
            n_fail++;
            $display("FAIL clean_len got=%0d/%0d exp=%0d/1", brush_cnt, state_0, CLEAN_MIN);
        end
    endtask

    task automatic test_evade_priority();
        int turn_cnt;
        turn_cnt = 0;
        do_reset();
        on = 1'b1; tick();
        on = 1'b0; dirt = 1'b1; obstacle = 1'b1; tick();
        dirt = 1'b0; obstacle = 1'b0;
        n_checks++;
        if (state_0 !== 3'd3) begin
            n_fail++;
            $display("FAIL evade_prio got=%0d exp=3", state_0);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
                n_fail++;
                $display("FAIL evade[%0d] got=%b exp=%b", i, {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
            end
            if (turn_en) turn_cnt++;
            tick();
        end
        n_checks++;
        if (turn_cnt != EVADE_N || state_0 !== 3'd1) begin
            n_fail++;
            $display("FAIL evade_len got=%0d/%0d exp=%0d/1", turn_cnt, state_0, EVADE_N);
        end
    endtask

    task automatic test_stuck();
        int turn_cnt;
        turn_cnt = 0;
        do_reset();
        on = 1'b1; tick();
        on = 1'b0; obstacle = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
                n_fail++;
                $display("FAIL stuck[%0d] got=%b exp=%b", i, {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
            end
            if (turn_en) turn_cnt++;
            tick();
        end
        obstacle = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (turn_cnt != (FAULT_EN ? 4 * EVADE_N : 20) || fault !== FAULT_EN) begin
            n_fail++;
            $display("FAIL stuck_fault got=%0d/%b exp=%0d/%b", turn_cnt, fault, FAULT_EN ? 4 * EVADE_N : 20, FAULT_EN);
        end
        power_off = 1'b1; tick();
        power_off = 1'b0;
        n_checks++;
        if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== 8'h00) begin
            n_fail++;
            $display("FAIL stuck_clear got=%b exp=%b", {state_0, motor_en, brush_en, turn_en, dock_req, fault}, 8'h00);
        end
    endtask

    task automatic test_battery();
        logic [7:0] t_batt [8] = '{8'd100, 8'd100, 8'd21, 8'd20, 8'd20, 8'd20, 8'd250, 8'd250};
        logic       t_on   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       t_dirt [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       t_dock [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] t_exp  [8] = '{3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd5, 3'd1, 3'd1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            on = t_on[i]; dirt = t_dirt[i]; docked = t_dock[i]; batt_level = t_batt[i];
            tick();
            n_checks++;
            if (state_0 !== t_exp[i] || {state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
                n_fail++;
                $display("FAIL battery[%0d] got=%b exp_state=%0d exp=%b", i, {state_0, motor_en, brush_en, turn_en, dock_req, fault}, t_exp[i], exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_evade();
        int turn_cnt;
        turn_cnt = 0;
        do_reset();
        on = 1'b1; tick();
        on = 1'b0; obstacle = 1'b1; tick();
        obstacle = 1'b0; tick();
        power_off = 1'b1; tick();
        power_off = 1'b0;
        n_checks++;
        if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== 8'h00) begin
            n_fail++;
            $display("FAIL midevade_off got=%b exp=%b", {state_0, motor_en, brush_en, turn_en, dock_req, fault}, 8'h00);
        end
        on = 1'b1; tick();
        on = 1'b0; obstacle = 1'b1; tick();
        obstacle = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (turn_en) turn_cnt++;
            tick();
        end
        n_checks++;
        if (turn_cnt != EVADE_N || state_0 !== 3'd1) begin
            n_fail++;
            $display("FAIL midevade_reentry got=%0d/%0d exp=%0d/1", turn_cnt, state_0, EVADE_N);
        end
    endtask

    task automatic test_low_start();
        do_reset();
        batt_level = 8'd15; on = 1'b1; tick();
        on = 1'b0;
        n_checks++;
        if (state_0 !== 3'd4 || motor_en !== 1'b1 || brush_en !== 1'b0 ||
            {state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
            n_fail++;
            $display("FAIL low_start got=%b exp=%b", {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            power_off = ($urandom_range(0, 127) == 0);
            on        = 1'($urandom_range(0, 1));
            dirt      = ($urandom_range(0, 3) == 0);
            obstacle  = ($urandom_range(0, 5) == 0);
            docked    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0: batt_level = 8'd19;
                    1: batt_level = 8'd20;
                    2: batt_level = 8'd21;
                    3: batt_level = 8'd249;
                    4: batt_level = 8'd250;
                    5: batt_level = 8'd255;
                    default: batt_level = 8'($urandom_range(22, 248));
                endcase
            end
            tick();
            n_checks++;
            if ({state_0, motor_en, brush_en, turn_en, dock_req, fault} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] got=%b exp=%b", i, {state_0, motor_en, brush_en, turn_en, dock_req, fault}, exp_vec());
            end
        end
    endtask

    initial begin
        m_st = 0; m_age = 0; m_retry = 0;
        test_reset();
        test_clean_dwell();
        test_evade_priority();
        test_stuck();
        test_battery();
        test_reset_mid_evade();
        test_low_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
